// File: rtl/csr_fifo_register_pkg.sv
// Shared constants and status packing for the CSR-mapped TX/RX FIFO pair.
package csr_fifo_register_pkg;

    localparam int ST_RX_EMPTY     = 0;
    localparam int ST_RX_FULL      = 1;
    localparam int ST_TX_EMPTY     = 2;
    localparam int ST_TX_FULL      = 3;
    localparam int ST_RX_UFLOW     = 4;
    localparam int ST_TX_OFLOW     = 5;
    localparam int CTL_RX_FLUSH    = 6;
    localparam int CTL_TX_FLUSH    = 7;
    localparam int ST_RX_COUNT_LSB = 8;
    localparam int ST_TX_COUNT_LSB = 16;
    localparam int ST_COUNT_W      = 8;

    typedef struct packed {
        logic       rx_empty;
        logic       rx_full;
        logic       tx_empty;
        logic       tx_full;
        logic       rx_uflow;
        logic       tx_oflow;
        logic [7:0] rx_count;
        logic [7:0] tx_count;
    } status_t;

    function automatic logic [31:0] pack_status(status_t s);
        logic [31:0] w;
        w = '0;
        w[ST_RX_EMPTY] = s.rx_empty;
        w[ST_RX_FULL]  = s.rx_full;
        w[ST_TX_EMPTY] = s.tx_empty;
        w[ST_TX_FULL]  = s.tx_full;
        w[ST_RX_UFLOW] = s.rx_uflow;
        w[ST_TX_OFLOW] = s.tx_oflow;
        w[ST_RX_COUNT_LSB +: ST_COUNT_W] = s.rx_count;
        w[ST_TX_COUNT_LSB +: ST_COUNT_W] = s.tx_count;
        return w;
    endfunction

endpackage

// File: rtl/csr_fifo.sv
// Power-of-two circular FIFO with flush; pops on empty are ignored and
// a push into a full FIFO is accepted only alongside a pop.
module csr_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             pop_eff;
    logic             push_eff;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign pop_eff  = pop && !empty;
    assign push_eff = push && (!full || pop_eff);
    assign head     = mem[rd_ptr];

    // Storage is intentionally not reset; only pointers define contents.
    always_ff @(posedge clk) begin
        if (push_eff) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_eff) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_eff) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_eff, pop_eff})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/csr_fifo_register.sv
// CSR-mapped FIFO port: data address pushes TX / pops RX, status address
// reports levels and sticky errors and accepts W1C and flush controls.
module csr_fifo_register
    import csr_fifo_register_pkg::*;
#(
    parameter logic [11:0] ADDRESS        = 12'h000,
    parameter logic [11:0] STATUS_ADDRESS = ADDRESS + 12'd1,
    parameter int          WIDTH          = 32,
    parameter int          DEPTH          = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             csrWriteEnable,
    input  logic             csrReadEnable,
    input  logic [11:0]      csrWriteAddress,
    input  logic [11:0]      csrReadAddress,
    input  logic [31:0]      csrWriteData,
    output logic [31:0]      csrReadData,
    output logic             csrRequestOutput,
    output logic [WIDTH-1:0] txData,
    output logic             txValid,
    input  logic             txReady,
    input  logic [WIDTH-1:0] rxData,
    input  logic             rxValid,
    output logic             rxReady
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          wr_data;
    logic          wr_stat;
    logic          rd_data;
    logic          rd_stat;
    logic          tx_push;
    logic          tx_pop;
    logic          tx_flush;
    logic          tx_full;
    logic          tx_empty;
    logic [CW-1:0] tx_count;
    logic          rx_push;
    logic          rx_pop;
    logic          rx_flush;
    logic          rx_full;
    logic          rx_empty;
    logic [CW-1:0] rx_count;
    logic [WIDTH-1:0] rx_head;
    logic [31:0]   rx_ext;
    logic          rx_uflow;
    logic          tx_oflow;
    logic          rx_uflow_set;
    logic          tx_oflow_set;
    logic          rx_uflow_clr;
    logic          tx_oflow_clr;
    status_t       status;
    logic          unused_bits;

    assign wr_data = csrWriteEnable && (csrWriteAddress == ADDRESS);
    assign wr_stat = csrWriteEnable && (csrWriteAddress == STATUS_ADDRESS);
    assign rd_data = csrReadEnable && (csrReadAddress == ADDRESS);
    assign rd_stat = csrReadEnable && (csrReadAddress == STATUS_ADDRESS);

    assign csrRequestOutput = rd_data || rd_stat;

    assign tx_push  = wr_data;
    assign tx_pop   = txValid && txReady;
    assign tx_flush = wr_stat && csrWriteData[CTL_TX_FLUSH];
    assign rx_push  = rxValid && rxReady;
    assign rx_pop   = rd_data && !rx_empty;
    assign rx_flush = wr_stat && csrWriteData[CTL_RX_FLUSH];

    assign txValid = !tx_empty;
    assign rxReady = !rx_full;

    assign rx_uflow_set = rd_data && rx_empty;
    assign tx_oflow_set = wr_data && tx_full && !tx_pop;
    assign rx_uflow_clr = wr_stat && csrWriteData[ST_RX_UFLOW];
    assign tx_oflow_clr = wr_stat && csrWriteData[ST_TX_OFLOW];

    assign unused_bits = ^csrWriteData;

    csr_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_tx (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (tx_pop),
        .flush (tx_flush),
        .din   (csrWriteData[WIDTH-1:0]),
        .head  (txData),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    csr_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_rx (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (rx_pop),
        .flush (rx_flush),
        .din   (rxData),
        .head  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    // A same-cycle set wins over write-1-to-clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_uflow <= 1'b0;
            tx_oflow <= 1'b0;
        end else begin
            rx_uflow <= rx_uflow_set | (rx_uflow & ~rx_uflow_clr);
            tx_oflow <= tx_oflow_set | (tx_oflow & ~tx_oflow_clr);
        end
    end

    always_comb begin
        status          = '0;
        status.rx_empty = rx_empty;
        status.rx_full  = rx_full;
        status.tx_empty = tx_empty;
        status.tx_full  = tx_full;
        status.rx_uflow = rx_uflow;
        status.tx_oflow = tx_oflow;
        status.rx_count = 8'(rx_count);
        status.tx_count = 8'(tx_count);
    end

    always_comb begin
        rx_ext = '0;
        rx_ext[WIDTH-1:0] = rx_head;
    end

    always_comb begin
        csrReadData = '0;
        unique case (1'b1)
            rd_data: csrReadData = rx_empty ? 32'd0 : rx_ext;
            rd_stat: csrReadData = pack_status(status);
            default: csrReadData = '0;
        endcase
    end

endmodule

// File: doc/csr_fifo_register.md
CSR_FIFO_REGISTER -- requirements
Module: csr_fifo_register

Interface
REQ-001 SHALL have parameter ADDRESS, default 12'h000: CSR address of the data port.
REQ-002 SHALL have parameter STATUS_ADDRESS, default ADDRESS+1: CSR address of the status/control port.
REQ-003 SHALL have parameter WIDTH, default 32: data width, legal range 1..32.
REQ-004 SHALL have parameter DEPTH, default 4: entries per FIFO, power of two, legal range 2..128.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports csrWriteEnable, csrReadEnable  input  1  CSR write/read strobes.
REQ-008 SHALL have ports csrWriteAddress, csrReadAddress  input  12  CSR addresses.
REQ-009 SHALL have port csrWriteData  input  32  CSR write data.
REQ-010 SHALL have port csrReadData  output  32  CSR read data, 0 when not addressed.
REQ-011 SHALL have port csrRequestOutput  output  1  high when a read targets ADDRESS or STATUS_ADDRESS with csrReadEnable.
REQ-012 SHALL have ports txData  output  WIDTH, txValid  output  1, txReady  input  1: TX FIFO head to system.
REQ-013 SHALL have ports rxData  input  WIDTH, rxValid  input  1, rxReady  output  1: system into RX FIFO.

Function
REQ-014 CSR write to ADDRESS SHALL push csrWriteData[WIDTH-1:0] into TX FIFO at the clock edge.
REQ-015 CSR read of ADDRESS SHALL return RX head zero-extended to 32 bits combinationally, and pop RX at the same clock edge.
REQ-016 CSR read of ADDRESS with RX empty SHALL return 0, pop nothing, set sticky rxUnderflow.
REQ-017 CSR write to ADDRESS with TX full and no same-cycle TX pop SHALL drop the data and set sticky txOverflow.
REQ-018 A push into a full FIFO SHALL be accepted when a pop of that FIFO occurs in the same cycle; count unchanged.
REQ-019 txValid SHALL equal TX not-empty; txData SHALL be TX head; TX pops on txValid && txReady.
REQ-020 rxReady SHALL equal RX not-full; RX pushes on rxValid && rxReady.
REQ-021 Status read layout: bit0 rxEmpty, bit1 rxFull, bit2 txEmpty, bit3 txFull, bit4 rxUnderflow, bit5 txOverflow, [15:8] rxCount, [23:16] txCount, others 0.
REQ-022 Status write: bit4/bit5 write-1-to-clear; bit6=1 flushes RX; bit7=1 flushes TX; other bits ignored.
REQ-023 Flush SHALL take priority over any same-cycle push/pop of that FIFO; FIFO empty next cycle.
REQ-024 Sticky set and W1C in the same cycle SHALL leave the flag set.
REQ-025 Pointers SHALL be log2(DEPTH) bits with natural wrap; counts log2(DEPTH)+1 bits, 0..DEPTH.
REQ-026 A pop-and-push to the same FIFO in one cycle while empty SHALL act as push only.
REQ-027 Status read SHALL have no side effects; status and data writes never alter the other FIFO.
REQ-028 Read and write strobes SHALL act independently when both present in one cycle.

Reset
REQ-029 While rst low: both FIFOs empty, pointers and counts 0, sticky flags 0, txValid 0, rxReady 1, csrReadData follows REQ-010.
REQ-030 Reset asserted mid-transfer SHALL discard all stored entries immediately; FIFO storage contents need not be cleared.

Structure
REQ-031 Status bit positions and flush/clear bit indices SHALL be constants in the shared core CSR package.
REQ-032 One sub-module csr_fifo (WIDTH, DEPTH; push/pop/flush, head, full/empty/count) SHALL be instantiated twice.

Verification
REQ-033 Reset, DEPTH=4: txValid=0, rxReady=1, status read = 0x00000005.
REQ-034 Write 0xA1,0xA2,0xA3 to ADDRESS, txReady=1 -> txData 0xA1,0xA2,0xA3 on consecutive cycles, then txValid=0.
REQ-035 txReady=0, five writes 1..5 -> first four stored, status txFull=1, txOverflow=1, txCount=4; write status 0x20 -> txOverflow=0.
REQ-036 Push 0x55 on rx, CSR read ADDRESS twice -> 0x55 then 0, rxUnderflow=1.
REQ-037 TX full, same-cycle txReady=1 and CSR write 0x99 -> accepted, txCount stays 4, no overflow; 0x99 emerges fourth.
REQ-038 RX holding 3 entries, write status 0x40 with simultaneous rxValid -> rxEmpty=1 next cycle, rxCount=0.
